// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and mtime behind a single-master load/store port,
// producing registered MTIP/MSIP levels. Define CLINT_PRESCALER_EN to divide the mtime tick by TICK_DIV.
module clint_timer #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned     TICK_DIV  = 16
) (
    input  logic              clk_sys_i,
    input  logic              rst_sys_i,
    input  logic              bus_read_ena_i,
    input  logic              bus_write_ena_i,
    input  logic [XLEN-1:0]   bus_addr_i,
    input  logic [XLEN-1:0]   bus_wdata_i,
    input  logic [XLEN/8-1:0] bus_wstrb_i,
    output logic [XLEN-1:0]   bus_rdata_o,
    output logic              bus_rvalid_o,
    output logic              bus_err_o,
    output logic              time_intr_o,
    output logic              software_intr_o,
    output logic [XLEN-1:0]   mtime_o
);

    localparam int unsigned     NBYTES       = XLEN / 8;
    localparam logic [XLEN-1:0] OFF_MSIP     = XLEN'(32'h0000_0000);
    localparam logic [XLEN-1:0] OFF_MTIMECMP = XLEN'(32'h0000_4000);
    localparam logic [XLEN-1:0] OFF_MTIME    = XLEN'(32'h0000_BFF8);
    localparam logic [XLEN-1:0] WIN_SIZE     = XLEN'(32'h0001_0000);

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old_v,
                                                    input logic [XLEN-1:0]   new_v,
                                                    input logic [NBYTES-1:0] strb);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int i = 0; i < NBYTES; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [XLEN-1:0] mtime_r;
    logic [XLEN-1:0] mtimecmp_r;
    logic            msip_r;
    logic [XLEN-1:0] rdata_r;
    logic            rvalid_r;
    logic            err_r;
    logic            time_intr_r;
    logic            software_intr_r;

    logic [XLEN-1:0] offset_s;
    logic            sel_msip_s;
    logic            sel_cmp_s;
    logic            sel_time_s;
    logic            legal_s;
    logic            rd_s;
    logic            wr_s;
    logic            access_err_s;
    logic            wr_live_s;
    logic            mtime_wr_s;
    logic            tick_s;
    logic [XLEN-1:0] rd_data_s;

    // Address decode and access classification
    always_comb begin
        offset_s     = bus_addr_i - BASE_ADDR;
        sel_msip_s   = 1'b0;
        sel_cmp_s    = 1'b0;
        sel_time_s   = 1'b0;
        if ((offset_s < WIN_SIZE) && (bus_addr_i[2:0] == 3'b000)) begin
            sel_msip_s = (offset_s == OFF_MSIP);
            sel_cmp_s  = (offset_s == OFF_MTIMECMP);
            sel_time_s = (offset_s == OFF_MTIME);
        end else begin
            sel_msip_s = 1'b0;
            sel_cmp_s  = 1'b0;
            sel_time_s = 1'b0;
        end
        legal_s      = sel_msip_s | sel_cmp_s | sel_time_s;
        rd_s         = bus_read_ena_i & ~bus_write_ena_i;
        wr_s         = bus_write_ena_i & ~bus_read_ena_i;
        // A read+write collision is rejected outright, regardless of address.
        access_err_s = (bus_read_ena_i & bus_write_ena_i) | ((rd_s | wr_s) & ~legal_s);
        wr_live_s    = wr_s & legal_s & (|bus_wstrb_i);
        mtime_wr_s   = wr_live_s & sel_time_s;
    end

    // Read data mux; unimplemented or illegal locations return zero
    always_comb begin
        rd_data_s = '0;
        if (sel_msip_s) begin
            rd_data_s = {{(XLEN-1){1'b0}}, msip_r};
        end else if (sel_cmp_s) begin
            rd_data_s = mtimecmp_r;
        end else if (sel_time_s) begin
            rd_data_s = mtime_r;
        end else begin
            rd_data_s = '0;
        end
    end

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned PW         = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 32'd1);

    logic [PW-1:0] presc_r;

    assign tick_s = (presc_r == PRESC_LAST);

    // Prescaler: wraps every TICK_DIV cycles, restarts when software writes mtime
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            presc_r <= '0;
        end else if (mtime_wr_s || tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1'b1);
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // Architectural registers; a software write to mtime overrides that cycle's tick
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            mtime_r    <= '0;
            mtimecmp_r <= '1;
            msip_r     <= 1'b0;
        end else begin
            if (wr_live_s && sel_msip_s && bus_wstrb_i[0]) begin
                msip_r <= bus_wdata_i[0];
            end
            if (wr_live_s && sel_cmp_s) begin
                mtimecmp_r <= merge_bytes(mtimecmp_r, bus_wdata_i, bus_wstrb_i);
            end
            if (mtime_wr_s) begin
                mtime_r <= merge_bytes(mtime_r, bus_wdata_i, bus_wstrb_i);
            end else if (tick_s) begin
                mtime_r <= mtime_r + XLEN'(1'b1);
            end
        end
    end

    // Response stage and interrupt levels, all one cycle behind the register state
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            rdata_r         <= '0;
            rvalid_r        <= 1'b0;
            err_r           <= 1'b0;
            time_intr_r     <= 1'b0;
            software_intr_r <= 1'b0;
        end else begin
            rdata_r         <= rd_s ? rd_data_s : '0;
            rvalid_r        <= rd_s;
            err_r           <= access_err_s;
            time_intr_r     <= (mtime_r >= mtimecmp_r);
            software_intr_r <= msip_r;
        end
    end

    assign bus_rdata_o     = rdata_r;
    assign bus_rvalid_o    = rvalid_r;
    assign bus_err_o       = err_r;
    assign time_intr_o     = time_intr_r;
    assign software_intr_o = software_intr_r;
    assign mtime_o         = mtime_r;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural register-map model.
module tb_clint_timer;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam int          TD   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] addr = 64'h0;
    logic [63:0] wdata = 64'h0;
    logic [7:0]  wstrb = 8'h0;
    logic [63:0] rdata;
    logic        rvalid;
    logic        err;
    logic        tint;
    logic        sint;
    logic [63:0] mtime;

    int n_checks = 0;
    int n_fail   = 0;

    clint_timer #(.XLEN(64), .BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .clk_sys_i       (clk),
        .rst_sys_i       (rst),
        .bus_read_ena_i  (rd),
        .bus_write_ena_i (wr),
        .bus_addr_i      (addr),
        .bus_wdata_i     (wdata),
        .bus_wstrb_i     (wstrb),
        .bus_rdata_o     (rdata),
        .bus_rvalid_o    (rvalid),
        .bus_err_o       (err),
        .time_intr_o     (tint),
        .software_intr_o (sint),
        .mtime_o         (mtime)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime, m_cmp, m_off;
    logic        m_msip, m_legal, m_time_written;
    int          m_cycles;
    logic [63:0] e_rdata;
    logic        e_rvalid, e_err, e_tint, e_sint;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mtime = 64'h0; m_cmp = '1; m_msip = 1'b0; m_cycles = 0;
            e_rdata = 64'h0; e_rvalid = 1'b0; e_err = 1'b0; e_tint = 1'b0; e_sint = 1'b0;
            model_on = 1'b1;
        end else begin
            // interrupt levels reflect the register state as it stood before this edge
            e_tint = (m_mtime >= m_cmp);
            e_sint = m_msip;
            m_off  = addr - BASE;
            m_legal = (addr >= BASE) && (addr < BASE + 64'h1_0000) && (addr % 8 == 0) &&
                      (m_off == 64'h0 || m_off == 64'h4000 || m_off == 64'hBFF8);
            e_rvalid = 1'b0; e_err = 1'b0; e_rdata = 64'h0; m_time_written = 1'b0;
            if (rd && wr) begin
                e_err = 1'b1;
            end else if (rd) begin
                e_rvalid = 1'b1;
                e_err    = !m_legal;
                if (m_legal && m_off == 64'h0)    e_rdata = {63'h0, m_msip};
                if (m_legal && m_off == 64'h4000) e_rdata = m_cmp;
                if (m_legal && m_off == 64'hBFF8) e_rdata = m_mtime;
            end else if (wr) begin
                e_err = !m_legal;
                if (m_legal) begin
                    for (int b = 0; b < 8; b++) begin
                        if (wstrb[b]) begin
                            if (m_off == 64'h0 && b == 0) m_msip = wdata[0];
                            if (m_off == 64'h4000) m_cmp[b*8 +: 8] = wdata[b*8 +: 8];
                            if (m_off == 64'hBFF8) begin
                                m_mtime[b*8 +: 8] = wdata[b*8 +: 8];
                                m_time_written = 1'b1;
                            end
                        end
                    end
                end
            end
`ifdef CLINT_PRESCALER_EN
            // one increment every TD cycles, counted from reset or the last mtime write
            if (m_time_written) begin
                m_cycles = 0;
            end else begin
                m_cycles++;
                if (m_cycles == TD) begin
                    m_cycles = 0;
                    m_mtime  = m_mtime + 64'd1;
                end
            end
`else
            if (!m_time_written) m_mtime = m_mtime + 64'd1;
`endif
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (model_on) begin
            check("rvalid", {63'h0, rvalid}, {63'h0, e_rvalid});
            check("err", {63'h0, err}, {63'h0, e_err});
            if (e_rvalid) check("rdata", rdata, e_rdata);
            check("time_intr", {63'h0, tint}, {63'h0, e_tint});
            check("software_intr", {63'h0, sint}, {63'h0, e_sint});
            check("mtime_o", mtime, m_mtime);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0; rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        addr = a; wdata = d; wstrb = s; wr = 1'b1; rd = 1'b0;
        step();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [63:0] d,
                            output logic v, output logic e);
        addr = a; rd = 1'b1; wr = 1'b0;
        step();
        d = rdata; v = rvalid; e = err;
        rd = 1'b0;
    endtask

    task automatic wait_mtime(input logic [63:0] val, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (mtime == val) found = 1'b1;
            else step();
        end
        check("wait_mtime_timeout", {63'h0, found}, 64'h1);
    endtask

    logic [63:0] rd_d;
    logic        rd_v, rd_e;

    initial begin
        do_reset();
        check("reset_mtime", mtime, 64'h0);
        check("reset_tint", {63'h0, tint}, 64'h0);
        check("reset_rvalid", {63'h0, rvalid}, 64'h0);

`ifndef CLINT_PRESCALER_EN
        // free-run, then read back the pre-increment value
        idle(10);
        check("freerun_mtime", mtime, 64'd10);
        check("freerun_sint", {63'h0, sint}, 64'h0);
        bus_read(BASE + 64'hBFF8, rd_d, rd_v, rd_e);
        check("read_mtime_val", rd_d, 64'd10);
        check("read_mtime_valid", {63'h0, rd_v}, 64'h1);
        check("read_mtime_after", mtime, 64'd11);
`endif

        // timer compare rise / fall
        do_reset();
        bus_write(BASE + 64'h4000, 64'd20, 8'hFF);
        wait_mtime(64'd20, 200);
        check("tint_before_rise", {63'h0, tint}, 64'h0);
        step();
        check("tint_rise", {63'h0, tint}, 64'h1);
        idle(5);
        check("tint_hold", {63'h0, tint}, 64'h1);
        bus_write(BASE + 64'h4000, 64'd1000, 8'hFF);
        check("tint_fall_lag", {63'h0, tint}, 64'h1);
        step();
        check("tint_fall", {63'h0, tint}, 64'h0);

        // software interrupt
        bus_write(BASE, 64'hFFFF_FFFF, 8'hFF);
        check("sint_lag", {63'h0, sint}, 64'h0);
        step();
        check("sint_set", {63'h0, sint}, 64'h1);
        bus_read(BASE, rd_d, rd_v, rd_e);
        check("msip_readback", rd_d, 64'h1);
        bus_write(BASE, 64'h0, 8'hFF);
        step();
        check("sint_clear", {63'h0, sint}, 64'h0);

        // wrap with mtimecmp=0
        bus_write(BASE + 64'h4000, 64'h0, 8'hFF);
        bus_write(BASE + 64'hBFF8, '1, 8'hFF);
        check("mtime_all_ones", mtime, '1);
        wait_mtime(64'h0, 2 * TD + 4);
        check("tint_at_wrap", {63'h0, tint}, 64'h1);
        step();
        check("tint_after_wrap", {63'h0, tint}, 64'h1);

        // error cases
        bus_read(BASE + 64'h8, rd_d, rd_v, rd_e);
        check("badrd_rdata", rd_d, 64'h0);
        check("badrd_rvalid", {63'h0, rd_v}, 64'h1);
        check("badrd_err", {63'h0, rd_e}, 64'h1);
        step();
        check("err_pulse", {63'h0, err}, 64'h0);
        bus_write(BASE + 64'h4000, 64'd1234, 8'hFF);
        bus_write(BASE + 64'h4004, 64'd5, 8'hFF);
        check("misaligned_err", {63'h0, err}, 64'h1);
        bus_read(BASE + 64'h4000, rd_d, rd_v, rd_e);
        check("cmp_unchanged", rd_d, 64'd1234);
        addr = BASE + 64'h4000; wdata = 64'd77; wstrb = 8'hFF; rd = 1'b1; wr = 1'b1;
        step();
        rd = 1'b0; wr = 1'b0;
        check("conflict_err", {63'h0, err}, 64'h1);
        check("conflict_rvalid", {63'h0, rvalid}, 64'h0);
        bus_read(BASE + 64'h4000, rd_d, rd_v, rd_e);
        check("conflict_cmp", rd_d, 64'd1234);
        bus_read(BASE + 64'h1_0000, rd_d, rd_v, rd_e);
        check("outside_hi_err", {63'h0, rd_e}, 64'h1);
        bus_read(BASE - 64'h8, rd_d, rd_v, rd_e);
        check("outside_lo_err", {63'h0, rd_e}, 64'h1);

`ifdef CLINT_PRESCALER_EN
        do_reset();
        idle(12);
        check("presc_12", mtime, 64'd3);
        idle(2);
        bus_write(BASE + 64'hBFF8, 64'd100, 8'hFF);
        idle(3);
        check("presc_hold", mtime, 64'd100);
        idle(1);
        check("presc_inc", mtime, 64'd101);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("presc_rst", mtime, 64'd0);
        idle(3);
        check("presc_rst_hold", mtime, 64'd0);
        idle(1);
        check("presc_rst_inc", mtime, 64'd1);
`endif

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 2000; i++) begin
            int          op, ap;
            logic [63:0] a;
            op = $urandom_range(0, 99);
            ap = $urandom_range(0, 9);
            case (ap)
                0, 1:    a = BASE;
                2, 3:    a = BASE + 64'h4000;
                4, 5:    a = BASE + 64'hBFF8;
                6:       a = BASE + 64'h8;
                7:       a = BASE + 64'h4000 + 64'($urandom_range(1, 7));
                8:       a = (($urandom_range(0, 1) == 0) ? BASE + 64'h1_0000 : BASE - 64'h8);
                default: a = {32'($urandom), 32'($urandom)};
            endcase
            addr  = a;
            wdata = (($urandom_range(0, 1) == 0) ? mtime + 64'($urandom_range(0, 40))
                                                 : {32'($urandom), 32'($urandom)});
            wstrb = (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
            rd    = (op < 35) || (op >= 90 && op < 94);
            wr    = (op >= 35 && op < 70) || (op >= 90 && op < 94);
            rst   = (op >= 97);
            step();
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor that generates the machine timer and software interrupt lines consumed by the CSR register file (time_intr_i, software_intr_i).
- Holds the memory-mapped msip, mtimecmp and mtime registers behind a simple single-master load/store port driven by the LSU.
- Sits upstream of the trap/CSR stage. Both interrupt outputs are registered level signals.

Parameters:
- XLEN, 64, data width; equals REG_WIDTH.
- BASE_ADDR, 64'h0200_0000, base byte address of the CLINT window.
- TICK_DIV, 16, clk_sys_i cycles per mtime increment; used only with CLINT_PRESCALER_EN; legal range 1..65535.

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_i  in  1  synchronous, active-high reset.
- bus_read_ena_i  in  1  read request, single-cycle pulse.
- bus_write_ena_i  in  1  write request, single-cycle pulse.
- bus_addr_i  in  XLEN  byte address.
- bus_wdata_i  in  XLEN  write data.
- bus_wstrb_i  in  XLEN/8  byte-lane write enables.
- bus_rdata_o  out  XLEN  read data.
- bus_rvalid_o  out  1  read data valid.
- bus_err_o  out  1  access error, one-cycle pulse.
- time_intr_o  out  1  machine timer interrupt pending (MTIP source).
- software_intr_o  out  1  machine software interrupt pending (MSIP source).
- mtime_o  out  XLEN  current mtime, for the time/cycle shadow.

Behaviour:
- Reset (rst_sys_i=1 at a clock edge): mtime=0, mtimecmp=all ones, msip=0, prescaler count=0. All outputs go to 0 on the next edge. Reset wins over every other event, including an in-flight access. That access is dropped: no rvalid and no err.
- Register map (offset = addr - BASE_ADDR):
  - 0x0000 msip: only bit 0 is implemented; other bits read 0; writes to them are ignored.
  - 0x4000 mtimecmp: read/write.
  - 0xBFF8 mtime: read/write.
- Access legality:
  - Any other offset inside the 64 KiB window is an error.
  - An address outside the window is an error.
  - addr[2:0]!=0 is an error.
- Read:
  - Latency is 1 cycle: rdata and rvalid are registered, and rvalid pulses for one cycle.
  - A read of mtime returns the value before any same-cycle increment.
  - An illegal read gives rvalid=1, rdata=0 and err=1, all in the same cycle.
- Write:
  - Takes effect at the request edge, per byte lane.
  - wstrb=0 is a legal no-op.
  - An illegal write changes no state; err pulses on the next cycle.
- read_ena and write_ena both high: illegal. Neither access executes; err pulses next cycle.
- Counter:
  - mtime increments by 1 per tick.
  - Without the prescaler, every cycle is a tick.
  - Wraps from all ones to 0 with no flag.
  - A write to mtime in the same cycle as a tick wins; the increment is lost that cycle.
- time_intr_o: registered (mtime >= mtimecmp), unsigned compare, evaluated on post-update values. Rises or falls one cycle after the mtime/mtimecmp change that causes it. Stays asserted until software raises mtimecmp or lowers mtime.
- software_intr_o: registered copy of msip[0]; one cycle after the write.
- mtime_o: combinational view of the mtime register.
- No state machine beyond the prescaler counter and the registered read-response stage. There is no back-pressure: one access is accepted per cycle.

Optional Feature:
- Macro CLINT_PRESCALER_EN.
- Defined:
  - A prescaler counter counts 0..TICK_DIV-1 and wraps to 0.
  - A tick occurs on the wrap.
  - A write to mtime resets the prescaler count to 0.
  - TICK_DIV=1 is equivalent to no prescaler.
- Undefined: no prescaler logic; mtime increments every cycle; TICK_DIV is ignored.

Test Plan:
- Reset, then free-run 10 cycles (macro off) -> mtime_o=10, time_intr_o=0, software_intr_o=0; read 0xBFF8 -> rvalid one cycle later with the pre-increment value.
- Write mtimecmp=20 with wstrb=0xFF, macro off, mtime starting at 0 -> time_intr_o rises on the cycle after mtime reaches 20 and stays high; then write mtimecmp=1000 -> time_intr_o falls one cycle later.
- Write msip=0xFFFF_FFFF -> software_intr_o=1 next cycle; readback returns 1; write 0 -> software_intr_o=0 next cycle.
- Write mtime=all ones, then mtimecmp=0 -> time_intr_o=1; next tick mtime wraps to 0 and time_intr_o stays 1 (0>=0).
- Error cases, each -> err one pulse and no state change:
  - Read offset 0x0008 -> rdata=0, rvalid=1, err=1.
  - Write addr BASE+0x4004 (misaligned) -> mtimecmp unchanged.
  - Simultaneous read and write.
- Macro on, TICK_DIV=4: 12 cycles -> mtime=3; write mtime=100 mid-period -> next increment 4 cycles after the write; assert reset mid-run -> mtime=0 and prescaler restarts.
